// File: rtl/pellet_tracker.sv
// Pellet state engine: scans one pellet per clock against the latched player
// hitbox, tracking the eaten bitmap, score, dots left, fright timer and level clear.
module pellet_tracker #(
  parameter int                N_DOTS        = 32,
  parameter int                COORD_W       = 10,
  parameter logic [N_DOTS-1:0] POWER_MASK    = '0,
  parameter int                DOT_PTS       = 10,
  parameter int                POWER_PTS     = 50,
  parameter int                SCORE_W       = 16,
  parameter logic [23:0]       FRIGHT_CYCLES = 24'd500000
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [N_DOTS*COORD_W-1:0]    dot_x,
  input  logic [N_DOTS*COORD_W-1:0]    dot_y,
  input  logic [COORD_W-1:0]           pX,
  input  logic [COORD_W-1:0]           pY,
  input  logic [COORD_W-1:0]           pS,
  input  logic                         frame_start,
  input  logic                         level_restart,
  output logic                         busy,
  output logic                         scan_done,
  output logic [N_DOTS-1:0]            eaten,
  output logic [$clog2(N_DOTS+1)-1:0]  dots_left,
  output logic                         eat_valid,
  output logic [$clog2(N_DOTS)-1:0]    eat_idx,
  output logic                         eat_power,
  output logic [SCORE_W-1:0]           score,
  output logic                         fright,
  output logic                         level_clear
);

  localparam int IW = $clog2(N_DOTS);
  localparam int DW = $clog2(N_DOTS+1);
  localparam int SW = SCORE_W + 32;
  localparam logic [SW-1:0] SCORE_MAX = SW'({SCORE_W{1'b1}});

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              state, next_state;
  logic [IW-1:0]       idx;
  logic [COORD_W-1:0]  lx, ly, ls;
  logic [23:0]         fright_cnt;
  logic                start, last, hit, is_power;
  logic [COORD_W-1:0]  cur_x, cur_y;
  logic signed [COORD_W:0] dx, dy;
  logic [COORD_W:0]    adx, ady;
  logic [31:0]         pts;
  logic [SW-1:0]       sum;
  logic [SCORE_W-1:0]  score_next;

  assign last = (idx == IW'(N_DOTS-1));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    busy       = 1'b0;
    scan_done  = 1'b0;
    case (state)
      IDLE: if (frame_start) begin
        next_state = SCAN;
        start      = 1'b1;
      end
      SCAN: begin
        busy = 1'b1;
        if (last) next_state = DONE;
      end
      DONE: begin
        scan_done = 1'b1;
        if (frame_start) begin
          next_state = SCAN;
          start      = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    // A restart dominates everything, including a coincident frame strobe.
    if (level_restart) begin
      next_state = IDLE;
      start      = 1'b0;
    end
  end

  // Differences carry one extra sign bit so coordinates near the edges never wrap.
  always_comb begin
    cur_x = dot_x[idx*COORD_W +: COORD_W];
    cur_y = dot_y[idx*COORD_W +: COORD_W];
    dx    = $signed({1'b0, cur_x}) - $signed({1'b0, lx});
    dy    = $signed({1'b0, cur_y}) - $signed({1'b0, ly});
    adx   = dx[COORD_W] ? -dx : dx;
    ady   = dy[COORD_W] ? -dy : dy;
    is_power = POWER_MASK[idx];
    hit   = (state == SCAN) && !level_restart && !eaten[idx] &&
            (adx <= {1'b0, ls}) && (ady <= {1'b0, ls});
    pts   = is_power ? 32'(POWER_PTS) : 32'(DOT_PTS);
    sum   = SW'(score) + SW'(pts);
    score_next = (sum > SCORE_MAX) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      idx         <= '0;
      lx          <= '0;
      ly          <= '0;
      ls          <= '0;
      eaten       <= '0;
      dots_left   <= DW'(N_DOTS);
      eat_valid   <= 1'b0;
      eat_idx     <= '0;
      eat_power   <= 1'b0;
      score       <= '0;
      fright_cnt  <= '0;
      level_clear <= 1'b0;
    end else begin
      eat_valid <= 1'b0;
      if (start) begin
        idx <= '0;
        lx  <= pX;
        ly  <= pY;
        ls  <= pS;
      end else if (state == SCAN && !last) begin
        idx <= idx + 1'b1;
      end
      if (level_restart) begin
        eaten       <= '0;
        dots_left   <= DW'(N_DOTS);
        level_clear <= 1'b0;
        fright_cnt  <= '0;
      end else begin
        if (hit) begin
          eaten[idx] <= 1'b1;
          dots_left  <= dots_left - 1'b1;
          eat_valid  <= 1'b1;
          eat_idx    <= idx;
          eat_power  <= is_power;
          score      <= score_next;
          if (dots_left == DW'(1)) level_clear <= 1'b1;
        end
        // Reload takes priority over the countdown, restarting the full duration.
        if (hit && is_power)         fright_cnt <= FRIGHT_CYCLES;
        else if (fright_cnt != '0)   fright_cnt <= fright_cnt - 1'b1;
      end
    end
  end

  assign fright = (fright_cnt != '0);

endmodule

// File: tb/tb_pellet_tracker.sv
// Scoreboard bench for pellet_tracker: a small 4-pellet maze with power pellets
// and an 8-pellet instance with a 6-bit score for saturation and edge coordinates.
module tb_pellet_tracker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance: 4 pellets, power pellets at 0 and 3.
  localparam logic [39:0] M_DX = {10'd300, 10'd300, 10'd100, 10'd200};
  localparam logic [39:0] M_DY = {10'd104, 10'd100, 10'd50,  10'd200};
  logic [9:0]  m_px = '0, m_py = '0, m_ps = '0;
  logic        m_frame = 1'b0, m_restart = 1'b0;
  logic        m_busy, m_done, m_eat_valid, m_eat_power, m_fright, m_clear;
  logic [3:0]  m_eaten;
  logic [2:0]  m_dots;
  logic [1:0]  m_eat_idx;
  logic [15:0] m_score;

  pellet_tracker #(
    .N_DOTS(4), .COORD_W(10), .POWER_MASK(4'b1001), .DOT_PTS(10),
    .POWER_PTS(50), .SCORE_W(16), .FRIGHT_CYCLES(24'd8)
  ) u_main (
    .Clk(clk), .Reset(rst_n), .dot_x(M_DX), .dot_y(M_DY),
    .pX(m_px), .pY(m_py), .pS(m_ps),
    .frame_start(m_frame), .level_restart(m_restart),
    .busy(m_busy), .scan_done(m_done), .eaten(m_eaten), .dots_left(m_dots),
    .eat_valid(m_eat_valid), .eat_idx(m_eat_idx), .eat_power(m_eat_power),
    .score(m_score), .fright(m_fright), .level_clear(m_clear)
  );

  // Saturation instance: pellets 0..6 stacked at (500,500), pellet 7 at (1020,0).
  localparam logic [79:0] S_DX = {10'd1020, {7{10'd500}}};
  localparam logic [79:0] S_DY = {10'd0,    {7{10'd500}}};
  logic [9:0]  s_px = '0, s_py = '0, s_ps = '0;
  logic        s_frame = 1'b0;
  logic        s_restart = 1'b0;
  logic        s_busy, s_done, s_eat_valid, s_eat_power, s_fright, s_clear;
  logic [7:0]  s_eaten;
  logic [3:0]  s_dots;
  logic [2:0]  s_eat_idx;
  logic [5:0]  s_score;

  pellet_tracker #(
    .N_DOTS(8), .COORD_W(10), .POWER_MASK(8'h00), .DOT_PTS(10),
    .POWER_PTS(50), .SCORE_W(6), .FRIGHT_CYCLES(24'd8)
  ) u_sat (
    .Clk(clk), .Reset(rst_n), .dot_x(S_DX), .dot_y(S_DY),
    .pX(s_px), .pY(s_py), .pS(s_ps),
    .frame_start(s_frame), .level_restart(s_restart),
    .busy(s_busy), .scan_done(s_done), .eaten(s_eaten), .dots_left(s_dots),
    .eat_valid(s_eat_valid), .eat_idx(s_eat_idx), .eat_power(s_eat_power),
    .score(s_score), .fright(s_fright), .level_clear(s_clear)
  );

  typedef struct {
    int idx;
    int power;
    int score;
    int dots;
    int cyc;
  } ev_t;

  ev_t mq[$];
  ev_t sq[$];
  int  m_done_q[$];
  int  s_done_q[$];
  ev_t me, se;
  int  md, sd;

  task automatic check_output(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) next_cycle();
  endtask

  task automatic push_ev(input bit main, input int idx, input int power,
                         input int score, input int dots, input int at);
    ev_t e;
    e.idx = idx; e.power = power; e.score = score; e.dots = dots; e.cyc = at;
    if (main) mq.push_back(e);
    else      sq.push_back(e);
  endtask

  // Strobes frame_start on the main instance; c is the cycle the strobe is driven in.
  task automatic apply_stimulus(input int x, input int y, input int s, output int c);
    m_px = 10'(x); m_py = 10'(y); m_ps = 10'(s);
    m_frame = 1'b1;
    c = cyc;
    next_cycle();
    m_frame = 1'b0;
  endtask

  task automatic sat_frame(input int x, input int y, input int s, output int c);
    s_px = 10'(x); s_py = 10'(y); s_ps = 10'(s);
    s_frame = 1'b1;
    c = cyc;
    next_cycle();
    s_frame = 1'b0;
  endtask

  // Monitor: every eat pulse and scan_done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (m_eat_valid) begin
      if (mq.size() == 0) check_output("main_eat_extra", 1, 0);
      else begin
        me = mq.pop_front();
        check_output("main_eat_idx",   int'(m_eat_idx),   me.idx);
        check_output("main_eat_power", int'(m_eat_power), me.power);
        check_output("main_eat_score", int'(m_score),     me.score);
        check_output("main_eat_dots",  int'(m_dots),      me.dots);
        check_output("main_eat_cycle", cyc,               me.cyc);
      end
    end
    if (m_done) begin
      if (m_done_q.size() == 0) check_output("main_done_extra", 1, 0);
      else begin
        md = m_done_q.pop_front();
        check_output("main_done_cycle", cyc, md);
      end
    end
    if (s_eat_valid) begin
      if (sq.size() == 0) check_output("sat_eat_extra", 1, 0);
      else begin
        se = sq.pop_front();
        check_output("sat_eat_idx",   int'(s_eat_idx), se.idx);
        check_output("sat_eat_score", int'(s_score),   se.score);
        check_output("sat_eat_dots",  int'(s_dots),    se.dots);
        check_output("sat_eat_cycle", cyc,             se.cyc);
      end
    end
    if (s_done) begin
      if (s_done_q.size() == 0) check_output("sat_done_extra", 1, 0);
      else begin
        sd = s_done_q.pop_front();
        check_output("sat_done_cycle", cyc, sd);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    repeat (3) next_cycle();
    check_output("rst_dots",  int'(m_dots),  4);
    check_output("rst_busy",  int'(m_busy),  0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("init_score", int'(m_score), 0);
    check_output("init_eaten", int'(m_eaten), 0);
    check_output("init_fright", int'(m_fright), 0);
    check_output("init_clear", int'(m_clear), 0);
    check_output("init_sat_dots", int'(s_dots), 8);

    // Single hit on pellet 1; player moves and a busy strobe arrives mid-scan.
    next_cycle();
    apply_stimulus(102, 48, 2, c);
    push_ev(1, 1, 0, 10, 3, c + 3);
    m_done_q.push_back(c + 5);
    check_output("single_busy", int'(m_busy), 1);
    m_px = 10'd200; m_py = 10'd200; m_ps = 10'd0;
    wait_until(c + 2);
    m_frame = 1'b1;
    next_cycle();
    m_frame = 1'b0;
    wait_until(c + 6);
    @(negedge clk);
    check_output("single_score", int'(m_score), 10);
    check_output("single_dots",  int'(m_dots),  3);
    check_output("single_eaten", int'(m_eaten), 4'b0010);
    check_output("single_fright", int'(m_fright), 0);

    // Power pellet 0, then back-to-back scan eating 2 and 3; pellet 3 reloads
    // fright in the very cycle the counter sits at 1.
    next_cycle();
    apply_stimulus(200, 200, 0, c);
    push_ev(1, 0, 1, 60, 2, c + 2);
    m_done_q.push_back(c + 5);
    for (int t = c + 1; t <= c + 19; t++) begin
      wait_until(t);
      if (t == c + 5) begin
        m_px = 10'd300; m_py = 10'd102; m_ps = 10'd2;
        m_frame = 1'b1;
        push_ev(1, 2, 0, 70, 1, c + 9);
        push_ev(1, 3, 1, 120, 0, c + 10);
        m_done_q.push_back(c + 10);
      end
      if (t == c + 6) m_frame = 1'b0;
      @(negedge clk);
      check_output("fright_window", int'(m_fright), (t >= c + 2 && t <= c + 17) ? 1 : 0);
      check_output("clear_rise",    int'(m_clear),  (t >= c + 10) ? 1 : 0);
    end
    check_output("clear_dots", int'(m_dots), 0);

    // Rescan over already-eaten pellets yields no events.
    next_cycle();
    apply_stimulus(300, 102, 2, c);
    m_done_q.push_back(c + 5);
    wait_until(c + 6);
    @(negedge clk);
    check_output("rescan_score", int'(m_score), 120);

    // Restart mid-scan: abort without scan_done, pellets restored, score kept.
    next_cycle();
    apply_stimulus(200, 200, 0, c);
    wait_until(c + 2);
    m_restart = 1'b1;
    next_cycle();
    m_restart = 1'b0;
    @(negedge clk);
    check_output("restart_busy",  int'(m_busy),  0);
    check_output("restart_eaten", int'(m_eaten), 0);
    check_output("restart_dots",  int'(m_dots),  4);
    check_output("restart_clear", int'(m_clear), 0);
    check_output("restart_score", int'(m_score), 120);
    wait_until(c + 8);

    // Eat power pellet again, then restart while frightened.
    apply_stimulus(200, 200, 0, c);
    push_ev(1, 0, 1, 170, 3, c + 2);
    wait_until(c + 3);
    @(negedge clk);
    check_output("refright_on", int'(m_fright), 1);
    wait_until(c + 4);
    m_restart = 1'b1;
    next_cycle();
    m_restart = 1'b0;
    @(negedge clk);
    check_output("restart_fright", int'(m_fright), 0);
    check_output("restart2_dots",  int'(m_dots),   4);
    check_output("restart2_score", int'(m_score),  170);
    check_output("restart2_busy",  int'(m_busy),   0);
    wait_until(c + 9);

    // Restart coincident with frame_start drops the frame.
    m_px = 10'd100; m_py = 10'd50; m_ps = 10'd0;
    m_frame = 1'b1;
    m_restart = 1'b1;
    c = cyc;
    next_cycle();
    m_frame = 1'b0;
    m_restart = 1'b0;
    @(negedge clk);
    check_output("coincident_busy", int'(m_busy), 0);
    wait_until(c + 7);
    check_output("coincident_dots", int'(m_dots), 4);

    // Edge coordinates: pellet 7 at x=1020 must not be hit from x=0.
    sat_frame(0, 0, 4, c);
    s_done_q.push_back(c + 9);
    wait_until(c + 10);
    @(negedge clk);
    check_output("nowrap_dots", int'(s_dots), 8);

    // Seven stacked pellets saturate the 6-bit score at 63.
    next_cycle();
    sat_frame(500, 500, 0, c);
    for (int j = 0; j < 7; j++)
      push_ev(0, j, 0, (10 * (j + 1) > 63) ? 63 : 10 * (j + 1), 7 - j, c + 2 + j);
    s_done_q.push_back(c + 9);
    wait_until(c + 10);
    @(negedge clk);
    check_output("sat_score", int'(s_score), 63);
    check_output("sat_dots",  int'(s_dots),  1);
    check_output("sat_clear", int'(s_clear), 0);

    // Asynchronous reset mid-scan, checked before the next clock edge.
    next_cycle();
    apply_stimulus(100, 50, 0, c);
    wait_until(c + 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("areset_busy",      int'(m_busy),      0);
    check_output("areset_done",      int'(m_done),      0);
    check_output("areset_eaten",     int'(m_eaten),     0);
    check_output("areset_dots",      int'(m_dots),      4);
    check_output("areset_eat_valid", int'(m_eat_valid), 0);
    check_output("areset_eat_idx",   int'(m_eat_idx),   0);
    check_output("areset_eat_power", int'(m_eat_power), 0);
    check_output("areset_score",     int'(m_score),     0);
    check_output("areset_fright",    int'(m_fright),    0);
    check_output("areset_clear",     int'(m_clear),     0);
    check_output("areset_sat_score", int'(s_score),     0);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    repeat (8) next_cycle();

    check_output("main_events_left", mq.size() + m_done_q.size(), 0);
    check_output("sat_events_left",  sq.size() + s_done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
